// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: packs a big-endian byte stream into
// 32-bit words, writes them to consecutive addresses, then verifies an XOR checksum.
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RECV  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] BASE     = BASE_ADDR[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [1:0]            idx_q, idx_d;
  logic [31:0]           shift_q, shift_d;
  logic [7:0]            chk_q, chk_d;
  logic                  err_q, err_d;
  logic                  xfer;

  // Handshake outputs depend only on state so byte_valid never loops back into byte_ready.
  assign byte_ready = (state_q == S_RECV) || (state_q == S_CHECK);
  assign imem_we    = (state_q == S_WRITE);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign imem_addr  = addr_q;
  assign imem_wdata = shift_q;
  assign err        = err_q;
  assign xfer       = byte_valid && byte_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    chk_d   = chk_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (word_count != '0) begin
            cnt_d   = word_count;
            addr_d  = BASE;
            idx_d   = 2'd0;
            chk_d   = 8'd0;
            state_d = S_RECV;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RECV: begin
        if (xfer) begin
          shift_d = {shift_q[23:0], byte_in};
          chk_d   = chk_q ^ byte_in;
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // Address wraps naturally at 2^ADDR_WIDTH.
        addr_d  = addr_q + ADDR_ONE;
        cnt_d   = cnt_q - CNT_ONE;
        state_d = (cnt_q == CNT_ONE) ? S_CHECK : S_RECV;
      end
      S_CHECK: begin
        if (xfer) begin
          err_d   = (byte_in != chk_q);
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      shift_q <= 32'd0;
      chk_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader; two instances cover the default
// geometry and a small wrapping address space (ADDR_WIDTH=2, BASE_ADDR=3).
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [8:0] wc;
  logic [7:0] bin;
  logic       bvalid;
  bit         sel;

  logic       rdy_a, we_a, busy_a, done_a, err_a;
  logic [7:0] addr_a;
  logic [31:0] wd_a;
  logic       rdy_b, we_b, busy_b, done_b, err_b;
  logic [1:0] addr_b;
  logic [31:0] wd_b;

  logic       rdy, we, busy, done, err;
  logic [7:0] addr;
  logic [31:0] wd;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int          xq[$];
  int          dq[$];
  int          wcq[$];
  logic [7:0]  waq[$];
  logic [31:0] wdq[$];
  logic [31:0] words[$];
  logic [31:0] mem [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rst(rst), .start(start && !sel), .word_count(wc),
    .byte_in(bin), .byte_valid(bvalid && !sel), .byte_ready(rdy_a),
    .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wd_a),
    .busy(busy_a), .done(done_a), .err(err_a));

  imem_loader #(.ADDR_WIDTH(2), .BASE_ADDR(3)) u_wrap (
    .clk(clk), .rst(rst), .start(start && sel), .word_count(wc[2:0]),
    .byte_in(bin), .byte_valid(bvalid && sel), .byte_ready(rdy_b),
    .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wd_b),
    .busy(busy_b), .done(done_b), .err(err_b));

  assign rdy  = sel ? rdy_b  : rdy_a;
  assign we   = sel ? we_b   : we_a;
  assign busy = sel ? busy_b : busy_a;
  assign done = sel ? done_b : done_a;
  assign err  = sel ? err_b  : err_a;
  assign addr = sel ? {6'd0, addr_b} : addr_a;
  assign wd   = sel ? wd_b   : wd_a;

  // Observe on the falling edge; cyc then names the cycle that began at the last rising edge.
  always @(negedge clk) begin
    if (bvalid && rdy) xq.push_back(cyc);
    if (we) begin
      waq.push_back(addr);
      wdq.push_back(wd);
      wcq.push_back(cyc);
      if (!sel) mem[addr] = wd;
    end
    if (done) dq.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    xq.delete(); dq.delete(); wcq.delete(); waq.delete(); wdq.delete();
  endtask

  function automatic logic [7:0] xsum();
    logic [7:0] x = 8'd0;
    foreach (words[i]) x ^= words[i][31:24] ^ words[i][23:16] ^ words[i][15:8] ^ words[i][7:0];
    return x;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic feed(input logic [7:0] b, input int gap);
    int guard = 0;
    bvalid = 1'b0;
    repeat (gap) tick();
    bvalid = 1'b1;
    bin    = b;
    while (!rdy && guard < 50) begin tick(); guard++; end
    if (!rdy) chk("ready_timeout", rdy, 1'b1);
    tick();
    bvalid = 1'b0;
  endtask

  // Full load of 'words' plus checksum byte chkb; expectations come from the word list alone.
  task automatic load(input logic [7:0] chkb, input int gmax, input bit poke);
    int aw   = sel ? 2 : 8;
    int base = sel ? 3 : 0;
    int n    = words.size();
    int guard = 0;
    clear_logs();
    start = 1'b1; wc = 9'(n);
    tick();
    start = 1'b0;
    chk("err_clr_on_start", err, 1'b0);
    chk("busy_on_start", busy, 1'b1);
    if (poke) begin start = 1'b1; wc = 9'd1; end
    foreach (words[i])
      for (int k = 3; k >= 0; k--)
        feed(words[i][8*k +: 8], $urandom_range(gmax, 0));
    start = 1'b0;
    feed(chkb, $urandom_range(gmax, 0));
    while (dq.size() == 0 && guard < 20) begin tick(); guard++; end
    if (dq.size() == 0) chk("done_timeout", dq.size(), 1);
    tick(); tick();
    chk("n_writes", waq.size(), n);
    chk("n_xfers", xq.size(), 4*n + 1);
    for (int i = 0; i < n && i < waq.size(); i++) begin
      chk("wr_addr", waq[i], (base + i) % (1 << aw));
      chk("wr_data", wdq[i], words[i]);
      if (xq.size() > 4*i + 3) chk("wr_lat", wcq[i], xq[4*i + 3] + 1);
    end
    chk("n_done", dq.size(), 1);
    if (dq.size() > 0 && xq.size() > 0) chk("done_lat", dq[0], xq[xq.size()-1] + 1);
    chk("err", err, chkb != xsum());
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 32'd0;
    rst = 1'b1; start = 1'b0; wc = '0; bin = '0; bvalid = 1'b0; sel = 1'b0;
    #2;
    chk("rst_ready", rdy_a, 1'b0);
    chk("rst_we",    we_a, 1'b0);
    chk("rst_busy",  busy_a, 1'b0);
    chk("rst_done",  done_a, 1'b0);
    chk("rst_err",   err_a, 1'b0);
    chk("rst_addr",  addr_a, 8'd0);
    chk("rst_wdata", wd_a, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reference two-word load, good and bad checksum.
    words = {32'h8C080004, 32'hAC090008};
    load(8'h2D, 0, 1'b0);
    load(8'h2C, 0, 1'b0);
    repeat (3) tick();
    chk("err_sticky_idle", err, 1'b1);
    chk("err_idle_busy", busy, 1'b0);
    // Gaps plus a start pulse held during the load, which must be ignored.
    load(8'h2D, 5, 1'b1);

    // Zero-word load: straight to DONE, no writes; start held in DONE is ignored.
    clear_logs();
    start = 1'b1; wc = 9'd0;
    tick();
    chk("wc0_busy", busy, 1'b1);
    chk("wc0_done", done, 1'b1);
    chk("wc0_we",   we, 1'b0);
    tick();
    start = 1'b0;
    chk("wc0_idle_busy", busy, 1'b0);
    chk("wc0_idle_done", done, 1'b0);
    tick();
    chk("wc0_stay_idle", busy, 1'b0);
    chk("wc0_no_write", waq.size(), 0);
    chk("wc0_err", err, 1'b0);

    // Wrap: 4 words into a 4-word space starting at 3.
    sel = 1'b1;
    words.delete();
    repeat (4) words.push_back($urandom);
    load(xsum(), 2, 1'b0);
    sel = 1'b0;
    tick();

    // Async reset after word 0 and two bytes of word 1.
    clear_logs();
    foreach (mem[i]) mem[i] = 32'd0;
    words = {32'h12345678, 32'h9ABCDEF0};
    start = 1'b1; wc = 9'd2;
    tick();
    start = 1'b0;
    for (int k = 3; k >= 0; k--) feed(words[0][8*k +: 8], 0);
    feed(8'h9A, 0);
    feed(8'hBC, 0);
    bvalid = 1'b1; bin = 8'hDE;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ready", rdy_a, 1'b0);
    chk("mid_rst_busy",  busy_a, 1'b0);
    chk("mid_rst_we",    we_a, 1'b0);
    chk("mid_rst_addr",  addr_a, 8'd0);
    chk("mid_rst_wdata", wd_a, 32'd0);
    tick();
    rst = 1'b0; bvalid = 1'b0;
    tick();
    chk("mid_rst_writes", waq.size(), 1);
    chk("mid_rst_mem0", mem[0], 32'h12345678);
    chk("mid_rst_mem1", mem[1], 32'd0);
    words = {32'hDEADBEEF, 32'h00000001, 32'h20080005};
    load(xsum(), 1, 1'b0);

    // Randomized loads against the reference rules.
    for (int t = 0; t < 6; t++) begin
      int n = $urandom_range(5, 1);
      logic [7:0] c;
      words.delete();
      repeat (n) words.push_back($urandom);
      c = xsum();
      if ($urandom_range(1, 0) == 1) c = c ^ 8'($urandom_range(255, 1));
      load(c, $urandom_range(3, 0), 1'(t % 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
